// File: rtl/rx_sample_packer_pkg.sv
// Shared constants for the RX sample packer.
// Sample widths, byte count and serializer state encoding.
package rx_sample_packer_pkg;

  localparam int SAMPLE_W         = 24;
  localparam int BYTES_PER_SAMPLE = 6;
  localparam int PAIR_W           = 2 * SAMPLE_W;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_SAMPLE - 1);

  // Byte 0 is the most significant byte of I.
  function automatic logic [7:0] pick_byte(
    input logic [PAIR_W-1:0] s,
    input logic [2:0]        idx
  );
    logic [PAIR_W-1:0] t;
    t = s << (8 * idx);
    return t[PAIR_W-1 -: 8];
  endfunction

endpackage

// File: rtl/rx_sample_packer_fifo.sv
// Synchronous I/Q pair FIFO with fill level.
// Caller guarantees no write while full unless popping.
module sync_sample_fifo
  import rx_sample_packer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = PAIR_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (wr_en) r_wptr <= r_wptr + 1'b1;
      if (rd_en) r_rptr <= r_rptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign rd_data = r_mem[r_rptr];
  assign full    = (r_level == LW'(DEPTH));
  assign empty   = (r_level == '0);
  assign level   = r_level;

endmodule

// File: rtl/rx_sample_packer.sv
// Buffers receiver I/Q pairs and streams them as
// six bytes per sample over a valid/ready port.
module rx_sample_packer
  import rx_sample_packer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_strobe,
  input  logic [SAMPLE_W-1:0]    in_data_I,
  input  logic [SAMPLE_W-1:0]    in_data_Q,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [15:0]            drop_count,
  input  logic                   clear_overflow
);

  logic [0:0]        r_state;
  logic [2:0]        r_idx;
  logic [PAIR_W-1:0] r_sample;
  logic              r_overflow;
  logic [15:0]       r_drops;

  logic              w_full;
  logic              w_empty;
  logic [PAIR_W-1:0] w_rd_data;
  logic              w_accept;
  logic              w_pop;
  logic              w_wr;
  logic              w_drop;

  assign w_accept = (r_state == ST_SEND) && out_ready;
  // Refill on the last accepted byte keeps samples back to back.
  assign w_pop    = !w_empty &&
                    ((r_state == ST_IDLE) ||
                     (w_accept && (r_idx == LAST_IDX)));
  assign w_wr     = in_strobe && (!w_full || w_pop);
  assign w_drop   = in_strobe && w_full && !w_pop;

  sync_sample_fifo #(
    .DEPTH (DEPTH),
    .W     (PAIR_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (w_wr),
    .wr_data ({in_data_I, in_data_Q}),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty),
    .level   (level)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_sample <= '0;
    end else if (w_pop) begin
      r_state  <= ST_SEND;
      r_idx    <= '0;
      r_sample <= w_rd_data;
    end else if (w_accept) begin
      if (r_idx == LAST_IDX) begin
        r_state <= ST_IDLE;
        r_idx   <= '0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // A drop in the clearing cycle restarts the count at one.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_drops    <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clear_overflow)
        r_drops <= 16'd1;
      else if (r_drops != 16'hFFFF)
        r_drops <= r_drops + 1'b1;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
      r_drops    <= '0;
    end
  end

  assign out_valid  = (r_state == ST_SEND);
  assign out_last   = out_valid && (r_idx == LAST_IDX);
  assign out_data   = out_valid ? pick_byte(r_sample, r_idx) : 8'h00;
  assign overflow   = r_overflow;
  assign drop_count = r_drops;

endmodule

// File: tb/tb_rx_sample_packer.sv
// Directed bench for rx_sample_packer.
// Bytes accepted on the output port are logged by a monitor.
module tb_rx_sample_packer;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_strobe = 1'b0;
  logic [23:0] in_data_I = '0;
  logic [23:0] in_data_Q = '0;
  logic        out_ready = 1'b0;
  logic        clear_overflow = 1'b0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic [$clog2(DEPTH):0] level;
  logic        overflow;
  logic [15:0] drop_count;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [7:0]  byte_q [$];
  logic        last_q [$];
  int          cyc_q  [$];
  logic [47:0] exp_q  [$];

  rx_sample_packer #(.DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_strobe      (in_strobe),
    .in_data_I      (in_data_I),
    .in_data_Q      (in_data_Q),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .level          (level),
    .overflow       (overflow),
    .drop_count     (drop_count),
    .clear_overflow (clear_overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      byte_q.push_back(out_data);
      last_q.push_back(out_last);
      cyc_q.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [47:0] samp(input int k);
    logic [7:0] b;
    b = 8'(k);
    return {8'hA0 + b, 8'h5A, b, 8'hC3, ~b, 8'h3C};
  endfunction

  function automatic logic [7:0] byte_of(input logic [47:0] s,
                                         input int j);
    logic [47:0] t;
    t = s >> (8 * (5 - j));
    return t[7:0];
  endfunction

  task automatic clear_log();
    byte_q.delete();
    last_q.delete();
    cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_strobe = 1'b0;
    clear_overflow = 1'b0;
    step();
    step();
    reset = 1'b0;
    clear_log();
  endtask

  task automatic strobe(input logic [47:0] s);
    in_strobe = 1'b1;
    {in_data_I, in_data_Q} = s;
    step();
    in_strobe = 1'b0;
  endtask

  task automatic drain(input int nbytes);
    int b;
    b = 0;
    while (byte_q.size() < nbytes && b < 400) begin
      step();
      b++;
    end
    if (byte_q.size() < nbytes)
      chk("drain_timeout", 64'(byte_q.size()), 64'(nbytes));
  endtask

  task automatic check_stream(input string tag);
    int k;
    chk({tag, "_len"}, 64'(byte_q.size()), 64'(exp_q.size() * 6));
    for (int i = 0; i < exp_q.size(); i++) begin
      for (int j = 0; j < 6; j++) begin
        k = i * 6 + j;
        if (k < byte_q.size()) begin
          chk({tag, "_data"}, byte_q[k], byte_of(exp_q[i], j));
          chk({tag, "_last"}, last_q[k], (j == 5));
        end
      end
    end
  endtask

  initial begin
    logic [47:0] s;
    int b;
    logic found;

    // reset state, with a strobe held high during reset
    reset = 1'b1;
    out_ready = 1'b1;
    in_strobe = 1'b1;
    {in_data_I, in_data_Q} = 48'hFFFFFF_FFFFFF;
    step();
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drops", drop_count, 0);

    // single sample, latency N+2
    reset = 1'b0;
    clear_log();
    in_strobe = 1'b1;
    in_data_I = 24'h123456;
    in_data_Q = 24'hABCDEF;
    step();
    in_strobe = 1'b0;
    chk("lat_n1_valid", out_valid, 0);
    chk("lat_n1_level", level, 1);
    step();
    s = 48'h123456_ABCDEF;
    for (int j = 0; j < 6; j++) begin
      chk("one_valid", out_valid, 1);
      chk("one_data", out_data, byte_of(s, j));
      chk("one_last", out_last, (j == 5));
      step();
    end
    chk("one_idle", out_valid, 0);
    chk("one_level", level, 0);

    // strobes every 8 cycles
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(samp(k));
      strobe(samp(k));
      for (int c = 0; c < 7; c++) begin
        chk("slow_level_le1", (level <= 1), 1);
        step();
      end
    end
    drain(24);
    check_stream("slow");
    chk("slow_ovf", overflow, 0);

    // back-to-back samples must stream with no bubble
    clear_log();
    exp_q.push_back(samp(40));
    exp_q.push_back(samp(41));
    strobe(samp(40));
    strobe(samp(41));
    drain(12);
    check_stream("b2b");
    for (int i = 1; i < cyc_q.size(); i++)
      chk("b2b_nobubble", 64'(cyc_q[i] - cyc_q[i-1]), 1);

    // overflow: DEPTH+2 strobes with the sink stalled
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH + 2; k++) begin
      if (k < DEPTH + 1) exp_q.push_back(samp(k));
      strobe(samp(k));
    end
    chk("ovf_level", level, DEPTH);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drops", drop_count, 1);
    out_ready = 1'b1;
    drain((DEPTH + 1) * 6);
    for (int c = 0; c < 10; c++) step();
    check_stream("ovf");
    chk("ovf_empty", level, 0);

    // write into a full FIFO in the cycle it pops
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH + 1; k++) begin
      exp_q.push_back(samp(k));
      strobe(samp(k));
    end
    chk("fullpop_pre_level", level, DEPTH);
    out_ready = 1'b1;
    b = 0;
    while (!(out_valid && out_last) && b < 20) begin
      step();
      b++;
    end
    chk("fullpop_found_last", (out_valid && out_last), 1);
    exp_q.push_back(samp(99));
    strobe(samp(99));
    chk("fullpop_level", level, DEPTH);
    chk("fullpop_drops", drop_count, 0);
    chk("fullpop_ovf", overflow, 0);
    drain((DEPTH + 2) * 6);
    check_stream("fullpop");

    // stall at byte 3, then reset mid-sample
    do_reset();
    out_ready = 1'b1;
    strobe(48'h112233_445566);
    strobe(48'h778899_AABBCC);
    found = 1'b0;
    b = 0;
    while (!found && b < 20) begin
      if (out_valid && out_data == 8'h44) found = 1'b1;
      else begin
        step();
        b++;
      end
    end
    chk("stall_found_b3", found, 1);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 8'h44);
      chk("stall_last", out_last, 0);
    end
    chk("stall_level", level, 1);
    out_ready = 1'b1;
    step();
    chk("stall_resume", out_data, 8'h55);
    reset = 1'b1;
    in_strobe = 1'b1;
    step();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_level", level, 0);
    chk("midrst_data", out_data, 0);
    step();
    reset = 1'b0;
    in_strobe = 1'b0;
    step();
    chk("postrst_level", level, 0);
    chk("postrst_valid", out_valid, 0);
    clear_log();
    exp_q.push_back(samp(7));
    strobe(samp(7));
    drain(6);
    check_stream("postrst");

    // clear coincident with a drop, then clear alone
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH + 3; k++) begin
      if (k < DEPTH + 1) exp_q.push_back(samp(k + 60));
      strobe(samp(k + 60));
    end
    chk("clr_pre_drops", drop_count, 2);
    chk("clr_pre_ovf", overflow, 1);
    clear_overflow = 1'b1;
    strobe(samp(200));
    chk("clr_drop_ovf", overflow, 1);
    chk("clr_drop_drops", drop_count, 1);
    step();
    clear_overflow = 1'b0;
    chk("clr_alone_ovf", overflow, 0);
    chk("clr_alone_drops", drop_count, 0);
    out_ready = 1'b1;
    drain((DEPTH + 1) * 6);
    check_stream("clr_intact");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
